tx_gearbox66: RTL and testbench
===============================

# tx_gearbox66

Transmit-side 66b-to-32b gearbox for the 64b/66b serial link. It accepts 66-bit blocks (2-bit sync header plus 64-bit payload) through a valid/ready handshake and emits one 32-bit word per enabled cycle, header bits first. When no user block is available it inserts idle control blocks, so the line never carries unframed bits and the receive-side header alignment always has a continuous stream of legal headers to lock on. It sits between the link framing logic and the 32-bit serializer/loopback path feeding the receive gearbox.

## Interface
- `IDLE_PAYLOAD`, default `64'h7800_0000_0000_0000`: payload of an inserted idle block.
- `IDLE_HEADER`, default `2'b10`: header of an inserted idle block. It must be `01` or `10`.
- `clk_i`, in, 1: single system clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `tx_en_i`, in, 1: serializer advance strobe. The gearbox acts only on cycles where it is 1.
- `blk_header_i`, in, 2: sync header. `01` is data, `10` is command.
- `blk_data_i`, in, 64: block payload.
- `blk_valid_i`, in, 1: a user block is offered.
- `blk_ready_o`, out, 1: combinational. A block is accepted on `blk_valid_i && blk_ready_o`.
- `tx_word_o`, out, 32: output word, registered.
- `tx_word_valid_o`, out, 1: `tx_word_o` holds a new word, registered.
- `idle_cnt_o`, out, 16: saturating count of inserted idle blocks.
- `hdr_err_o`, out, 1: one-cycle pulse when an accepted user block has header `00` or `11`.

## Operation
- Storage is a 98-bit shift buffer `buf` plus a 7-bit `fill` count (0..97).
  - Valid bits are MSB-aligned and occupy `buf[97 -: fill]`.
  - Bits transmit MSB-first; a block occupies bits {header[1:0], data[63:0]}.
- On each cycle with `tx_en_i=1`, two steps happen in order:
  1. **Emit.**
     - If `fill >= 32`: `tx_word_o <= buf[97:66]`, `tx_word_valid_o <= 1`, the buffer shifts left by 32, and `fill_post = fill - 32`.
     - Otherwise: `tx_word_valid_o <= 0` and `fill_post = fill`.
  2. **Load.** Only if `fill_post < 32`:
     - If `blk_valid_i=1`, the user block is written at `buf[97 - fill_post -: 66]`.
     - Otherwise an idle block {`IDLE_HEADER`, `IDLE_PAYLOAD`} is written there and `idle_cnt_o` increments, saturating at `16'hFFFF`.
     - Either way, `fill <= fill_post + 66`.
- `blk_ready_o = tx_en_i && (fill_post < 32)`, where `fill_post` is computed combinationally from the current `fill`.
- A user block with an illegal header is still transmitted unchanged. `hdr_err_o` is registered and pulses in the cycle after acceptance.
- While `tx_en_i=0`:
  - `buf`, `fill` and `idle_cnt_o` hold.
  - `tx_word_o` holds its last value; `tx_word_valid_o <= 0`; `blk_ready_o = 0`.
- Width rules:
  - `fill` never exceeds 97, since 31 + 66 is the maximum.
  - Loads happen only when `fill_post <= 31`, so the buffer never overflows.
  - Bits of `buf` below the valid region are don't-care, but must be zero after reset.

## Timing
- Reset (asynchronous assert; deassert synchronised externally) sets all of the following to zero:
  - `buf`, `fill`
  - `tx_word_o`, `tx_word_valid_o`
  - `idle_cnt_o`, `hdr_err_o`
- Reset in mid-operation discards any partially sent block. After release, the first enabled cycle loads a block and emits nothing.
- Latency: a block accepted on enabled cycle N has its header bits at `tx_word_o[31:30]` of the word valid after enabled cycle N+1, when the buffer is empty at acceptance.
- Steady state with `tx_en_i` held at 1:
  - A word is valid every cycle from the 2nd enabled cycle onward.
  - Exactly 16 loads occur every 33 enabled cycles.
  - `fill` after load runs 66, 68, …, 96. The pattern then includes two no-load cycles at 64 and 32, after which `fill` returns to 66.
- Stalls on `tx_en_i` stretch this pattern without altering the bit stream.

## Test plan
- **Back-to-back user blocks.**
  - Stimulus: reset, then `tx_en_i=1`; user blocks B0..B31 always valid, with B0 = {`01`, `64'h0123_4567_89AB_CDEF`}.
  - Required response: `tx_word_valid_o` is 0 after the first enabled cycle and 1 every cycle after that. The first word is `{2'b01, 30'h0048_D159}`, i.e. B0 bits [65:34]. The third word is `{B0[1:0], B1[65:36]}`. `blk_ready_o` is high on exactly 16 of every 33 cycles. `idle_cnt_o` stays 0.
- **Idle insertion.**
  - Stimulus: `blk_valid_i=0` throughout with `tx_en_i=1` for 66 cycles.
  - Required response: the stream is a repeating `IDLE_HEADER`/`IDLE_PAYLOAD` pattern, and `idle_cnt_o=32` after the 66th cycle.
- **Alignment recovery.**
  - Stimulus: the concatenated output is fed to the receive gearbox/header seeker.
  - Required response: the seeker locks, and the recovered 66b blocks match the input sequence bit-exactly.
- **Enable stalls.**
  - Stimulus: `tx_en_i` toggled pseudo-randomly at 50% duty.
  - Required response: the concatenated valid words equal the same bit stream as with `tx_en_i` held at 1. No word appears while `tx_en_i=0`, and no block is accepted then.
- **Illegal header.**
  - Stimulus: a block with header `11` is accepted.
  - Required response: `hdr_err_o` pulses for one cycle, and the `11` header appears unchanged in the output.
- **Reset in mid-block.**
  - Stimulus: `rst_ni` asserted with `fill=50`.
  - Required response: all outputs go to 0 immediately. After release, the stream restarts with the next accepted block at `tx_word_o[31:30]`.

Source files
------------

// File: rtl/tx_gearbox66.sv
// -----------------------------------------------------------------------------
// tx_gearbox66 - transmit-side 66b -> 32b gearbox for the 64b/66b serial link.
//
// Accepts 66-bit blocks {header[1:0], payload[63:0]} over a valid/ready
// handshake and emits one 32-bit word per enabled cycle, header bits first.
// Whenever the buffer needs refilling and no user block is offered, an idle
// control block is inserted so the line always carries legal sync headers.
//
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   tx_en_i           : serializer advance strobe; nothing moves while low
//   blk_header_i      : sync header of the offered block (01 data, 10 command)
//   blk_data_i        : 64-bit payload of the offered block
//   blk_valid_i       : a user block is offered
//   blk_ready_o       : combinational; block accepted on valid && ready
//   tx_word_o         : registered 32-bit output word (MSB transmitted first)
//   tx_word_valid_o   : registered; tx_word_o holds a new word
//   idle_cnt_o        : saturating count of inserted idle blocks
//   hdr_err_o         : one-cycle pulse after accepting a block with header 00/11
// -----------------------------------------------------------------------------
module tx_gearbox66 #(
  parameter logic [63:0] IDLE_PAYLOAD = 64'h7800_0000_0000_0000,
  parameter logic [1:0]  IDLE_HEADER  = 2'b10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tx_en_i,
  input  logic [1:0]  blk_header_i,
  input  logic [63:0] blk_data_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  output logic [31:0] tx_word_o,
  output logic        tx_word_valid_o,
  output logic [15:0] idle_cnt_o,
  output logic        hdr_err_o
);

  // Valid bits sit MSB-aligned in sbuf_q[97 -: fill_q]; bits below the valid
  // region are kept at zero because the left shift only ever brings in zeros.
  logic [97:0] sbuf_q, sbuf_d, sbuf_post;
  logic [6:0]  fill_q, fill_d, fill_post;
  logic [31:0] tx_word_q, tx_word_d;
  logic        tx_word_valid_q, tx_word_valid_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        hdr_err_q, hdr_err_d;

  logic        emit;
  logic        load;
  logic [65:0] blk_in;

  always_comb begin
    // NOTE: every variable gets a value before any conditional update, so no
    // path leaves one unassigned and no latch is inferred.
    emit      = tx_en_i && (fill_q >= 7'd32);
    fill_post = emit ? (fill_q - 7'd32) : fill_q;
    sbuf_post = emit ? {sbuf_q[65:0], 32'b0} : sbuf_q;

    // Refill only once less than one output word remains after the emit;
    // 31 + 66 = 97 is the largest fill, so the 98-bit buffer never overflows.
    load   = tx_en_i && (fill_post < 7'd32);
    blk_in = blk_valid_i ? {blk_header_i, blk_data_i} : {IDLE_HEADER, IDLE_PAYLOAD};

    sbuf_d          = sbuf_post;
    fill_d          = fill_post;
    tx_word_d       = emit ? sbuf_q[97:66] : tx_word_q;
    tx_word_valid_d = emit;
    idle_cnt_d      = idle_cnt_q;
    hdr_err_d       = 1'b0;

    if (load) begin
      sbuf_d[7'd97 - fill_post -: 66] = blk_in;
      fill_d                          = fill_post + 7'd66;
      if (!blk_valid_i) begin
        if (idle_cnt_q != 16'hFFFF) idle_cnt_d = idle_cnt_q + 16'd1;
      end else begin
        // Illegal headers are still sent unchanged; they are only flagged.
        hdr_err_d = (blk_header_i == 2'b00) || (blk_header_i == 2'b11);
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order. The shift buffer is
  // reset too: a mid-block reset must discard any partially sent block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbuf_q          <= '0;
      fill_q          <= '0;
      tx_word_q       <= '0;
      tx_word_valid_q <= 1'b0;
      idle_cnt_q      <= '0;
      hdr_err_q       <= 1'b0;
    end else begin
      sbuf_q          <= sbuf_d;
      fill_q          <= fill_d;
      tx_word_q       <= tx_word_d;
      tx_word_valid_q <= tx_word_valid_d;
      idle_cnt_q      <= idle_cnt_d;
      hdr_err_q       <= hdr_err_d;
    end
  end

  assign blk_ready_o     = load;
  assign tx_word_o       = tx_word_q;
  assign tx_word_valid_o = tx_word_valid_q;
  assign idle_cnt_o      = idle_cnt_q;
  assign hdr_err_o       = hdr_err_q;

endmodule

// File: tb/tb_tx_gearbox66.sv
// -----------------------------------------------------------------------------
// tb_tx_gearbox66 - self-checking bench for tx_gearbox66.
// The reference model treats the line as a plain queue of bits: each enabled
// cycle pops 32 bits if available, then appends a whole 66-bit block if fewer
// than 32 remain. Literal expectations pin the model for the first words.
// -----------------------------------------------------------------------------
module tb_tx_gearbox66;

  localparam logic [63:0] IDLE_P = 64'h7800_0000_0000_0000;
  localparam logic [1:0]  IDLE_H = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic [1:0]  blk_header;
  logic [63:0] blk_data;
  logic        blk_valid;
  logic        blk_ready;
  logic [31:0] tx_word;
  logic        tx_word_valid;
  logic [15:0] idle_cnt;
  logic        hdr_err;

  tx_gearbox66 #(
    .IDLE_PAYLOAD(IDLE_P),
    .IDLE_HEADER (IDLE_H)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tx_en_i        (tx_en),
    .blk_header_i   (blk_header),
    .blk_data_i     (blk_data),
    .blk_valid_i    (blk_valid),
    .blk_ready_o    (blk_ready),
    .tx_word_o      (tx_word),
    .tx_word_valid_o(tx_word_valid),
    .idle_cnt_o     (idle_cnt),
    .hdr_err_o      (hdr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state
  bit          mq[$];
  logic [31:0] exp_word;
  logic        exp_valid;
  logic [15:0] exp_idle;
  logic        exp_hdr_err;

  logic [31:0] words[$];      // DUT words observed in the current test
  logic [31:0] ref_words[$];  // stream from the back-to-back run

  logic [1:0]  bh[40];
  logic [63:0] bd[40];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_word    = '0;
    exp_valid   = 1'b0;
    exp_idle    = '0;
    exp_hdr_err = 1'b0;
  endtask

  task automatic do_reset();
    tx_en      = 1'b0;
    blk_valid  = 1'b0;
    blk_header = '0;
    blk_data   = '0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset tx_word", tx_word, 0);
    check("reset tx_word_valid", tx_word_valid, 0);
    check("reset idle_cnt", idle_cnt, 0);
    check("reset hdr_err", hdr_err, 0);
    rst_n = 1'b1;
    model_clear();
    words.delete();
  endtask

  // One clock cycle: drive inputs, check ready against the model, advance the
  // model, then check the registered outputs just after the edge.
  task automatic step(input logic en, input logic v, input logic [1:0] h,
                      input logic [63:0] d, output bit acc);
    bit          emit;
    int          post;
    logic [65:0] blk;
    @(negedge clk);
    tx_en = en; blk_valid = v; blk_header = h; blk_data = d;
    #1;
    emit = en && (mq.size() >= 32);
    post = emit ? mq.size() - 32 : mq.size();
    acc  = en && v && (post < 32);
    check("blk_ready", blk_ready, en && (post < 32));
    exp_valid   = emit;
    exp_hdr_err = 1'b0;
    if (emit)
      for (int i = 0; i < 32; i++) exp_word[31-i] = mq.pop_front();
    if (en && post < 32) begin
      blk = v ? {h, d} : {IDLE_H, IDLE_P};
      for (int i = 65; i >= 0; i--) mq.push_back(blk[i]);
      if (!v) begin
        if (exp_idle != 16'hFFFF) exp_idle++;
      end else begin
        exp_hdr_err = (h == 2'b00) || (h == 2'b11);
      end
    end
    @(posedge clk);
    #1;
    check("tx_word_valid", tx_word_valid, exp_valid);
    check("tx_word", tx_word, exp_word);
    check("idle_cnt", idle_cnt, exp_idle);
    check("hdr_err", hdr_err, exp_hdr_err);
    if (tx_word_valid) words.push_back(tx_word);
  endtask

  initial begin
    bit   acc;
    int   idx;
    int   rdy1, rdy2;
    bit   sbits[$];
    int   lock;
    logic [65:0] rec;

    rst_n = 1'b0;
    tx_en = 1'b0; blk_valid = 1'b0; blk_header = '0; blk_data = '0;
    model_clear();

    bh[0] = 2'b01; bd[0] = 64'h0123_4567_89AB_CDEF;
    bh[1] = 2'b10; bd[1] = 64'hFEDC_BA98_7654_3210;
    for (int i = 2; i < 40; i++) begin
      bh[i] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      bd[i] = {$urandom, $urandom};
    end

    // ---------------- Back-to-back user blocks ----------------
    do_reset();
    idx = 0; rdy1 = 0; rdy2 = 0;
    for (int c = 0; c < 66; c++) begin
      step(1'b1, 1'b1, bh[idx], bd[idx], acc);
      if (acc) begin
        idx++;
        if (c < 33) rdy1++; else rdy2++;
      end
    end
    check("b2b word count", words.size(), 65);
    check("b2b blocks accepted", idx, 32);
    check("b2b ready cycles 1..33", rdy1, 16);
    check("b2b ready cycles 34..66", rdy2, 16);
    check("b2b idle_cnt", idle_cnt, 0);
    check("b2b word0", words[0], 32'h4048_D159);
    check("b2b word1", words[1], 32'hE26A_F37B);
    check("b2b word2", words[2], 32'hEFED_CBA9);
    ref_words = words;

    // ---------------- Alignment recovery ----------------
    sbits.delete();
    foreach (ref_words[i])
      for (int b = 31; b >= 0; b--) sbits.push_back(ref_words[i][b]);
    lock = -1;
    for (int off = 0; off < 66 && lock < 0; off++) begin
      bit ok = 1'b1;
      for (int p = off; p + 1 < sbits.size(); p += 66)
        if (sbits[p] == sbits[p+1]) ok = 1'b0;
      if (ok) lock = off;
    end
    check("seeker lock offset", lock, 0);
    for (int k = 0; k < 31; k++) begin
      for (int b = 0; b < 66; b++) rec[65-b] = sbits[66*k + b];
      check($sformatf("recovered block %0d", k), rec, {bh[k], bd[k]});
    end

    // ---------------- Idle insertion ----------------
    do_reset();
    for (int c = 0; c < 66; c++) step(1'b1, 1'b0, 2'b00, 64'h0, acc);
    check("idle idle_cnt after 66", idle_cnt, 32);
    check("idle word0", words[0], 32'h9E00_0000);
    check("idle word2", words[2], 32'h2780_0000);

    // ---------------- Enable stalls ----------------
    do_reset();
    idx = 0;
    for (int c = 0; c < 400 && words.size() < 65; c++) begin
      step(($urandom_range(0, 1) == 1), 1'b1, bh[idx], bd[idx], acc);
      if (acc) idx++;
    end
    check("stall word count", words.size(), 65);
    for (int i = 0; i < 65; i++)
      check($sformatf("stall word %0d", i), words[i], ref_words[i]);

    // ---------------- Illegal header ----------------
    do_reset();
    step(1'b1, 1'b1, 2'b11, 64'hA5A5_5A5A_0F0F_F0F0, acc);
    check("illegal accepted", acc, 1);
    check("illegal hdr_err pulse", hdr_err, 1);
    step(1'b1, 1'b0, 2'b00, 64'h0, acc);
    check("illegal hdr_err cleared", hdr_err, 0);
    check("illegal header in stream", words[0][31:30], 2'b11);

    // ---------------- Reset in mid-block (fill = 50) ----------------
    do_reset();
    for (int c = 0; c < 18; c++) step(1'b1, 1'b0, 2'b00, 64'h0, acc);
    check("pre-reset model fill", mq.size(), 50);
    @(negedge clk);
    #2;
    tx_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid reset tx_word", tx_word, 0);
    check("mid reset tx_word_valid", tx_word_valid, 0);
    check("mid reset idle_cnt", idle_cnt, 0);
    check("mid reset hdr_err", hdr_err, 0);
    #1;
    rst_n = 1'b1;
    model_clear();
    words.delete();
    step(1'b1, 1'b1, 2'b01, 64'h3FFF_0000_1234_5678, acc);
    check("post-reset first cycle no word", tx_word_valid, 0);
    step(1'b1, 1'b0, 2'b00, 64'h0, acc);
    check("post-reset header position", words[0][31:30], 2'b01);
    check("post-reset first word", words[0], 32'h4FFF_C000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
